// File: rtl/dac_multi_controller.sv
// Multi-channel SPI DAC controller: serialises {addr,data} frames for each masked channel, mode 0, MSB first.
// Optional feature macro DAC_LDAC_EN adds the dac_ldac_n port and a simultaneous-update LDAC pulse.
module dac_multi_controller #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_dac,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] dac_vals,
  output logic                     busy,
  output logic                     dac_done,
  output logic                     spi_clk,
  output logic                     spi_mosi,
  output logic                     spi_cs
`ifdef DAC_LDAC_EN
  ,
  output logic                     dac_ldac_n
`endif
);

  localparam int F     = ADDR_W + DATA_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(F + 1);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, SELECT, SETUP, SHIFT, GAP, LDAC, DONE
  } state_t;

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic                       phase, phase_n;   // 0: spi_clk high half, 1: low half
  logic [BIT_W-1:0]           bit_idx, bit_n;
  logic [NUM_CH-1:0]          pend, pend_n;
  logic [F-1:0]               frame, frame_n;
  logic [NUM_CH*DATA_W-1:0]   vals;
  logic                       latch;
  logic [CH_W-1:0]            sel;

  logic busy_n, done_n, clk_n, mosi_n, cs_n;
`ifdef DAC_LDAC_EN
  logic ldac_n_n;
`endif

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  // Channel index wraps to ADDR_W bits when there are more channels than addresses.
  function automatic logic [ADDR_W-1:0] ch_addr(input logic [CH_W-1:0] ch);
    logic [31:0] w;
    w = 32'(ch);
    return w[ADDR_W-1:0];
  endfunction

  assign sel = lowest_set(pend);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phase_n = phase;
    bit_n   = bit_idx;
    pend_n  = pend;
    frame_n = frame;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (start_dac) begin
          latch   = 1'b1;
          pend_n  = ch_mask;
          cnt_n   = '0;
          state_n = (ch_mask == '0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        frame_n = {ch_addr(sel), vals[int'(sel)*DATA_W +: DATA_W]};
        pend_n  = pend & ~(NUM_CH'(1) << sel);
        cnt_n   = '0;
        state_n = SETUP;
      end
      SETUP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_n   = '0;
          phase_n = 1'b0;
          bit_n   = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_n = '0;
          if (!phase) begin
            // Falling edge: present the next bit; the last bit is held until GAP.
            phase_n = 1'b1;
            if (bit_idx != BIT_W'(F - 1)) frame_n = {frame[F-2:0], 1'b0};
          end else if (bit_idx == BIT_W'(F - 1)) begin
            state_n = GAP;
          end else begin
            bit_n   = bit_idx + BIT_W'(1);
            phase_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(CS_GAP - 1)) begin
          cnt_n = '0;
          if (pend != '0) begin
            state_n = SELECT;
          end else begin
`ifdef DAC_LDAC_EN
            state_n = LDAC;
`else
            state_n = DONE;
`endif
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef DAC_LDAC_EN
      LDAC: begin
        if (cnt == CNT_W'(2 * CLK_DIV - 1)) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output flops are loaded from the next-state decode so pins stay glitch-free and aligned with state.
  always_comb begin
    cs_n   = !((state_n == SETUP) || (state_n == SHIFT));
    clk_n  = (state_n == SHIFT) && !phase_n;
    mosi_n = ((state_n == SETUP) || (state_n == SHIFT)) ? frame_n[F-1] : 1'b0;
    busy_n = !((state_n == IDLE) || (state_n == DONE));
    done_n = (state_n == DONE);
`ifdef DAC_LDAC_EN
    ldac_n_n = (state_n != LDAC);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= 1'b0;
      bit_idx  <= '0;
      pend     <= '0;
      busy     <= 1'b0;
      dac_done <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs   <= 1'b1;
`ifdef DAC_LDAC_EN
      dac_ldac_n <= 1'b1;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      bit_idx  <= bit_n;
      pend     <= pend_n;
      busy     <= busy_n;
      dac_done <= done_n;
      spi_clk  <= clk_n;
      spi_mosi <= mosi_n;
      spi_cs   <= cs_n;
`ifdef DAC_LDAC_EN
      dac_ldac_n <= ldac_n_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    frame <= frame_n;
    if (latch) vals <= dac_vals;
  end

endmodule
